adpll_ref_lock_monitor: RTL and testbench
=========================================

# adpll_ref_lock_monitor

Drives the ring-oscillator ADPLL's reference clock from the FPGA clock and checks that loop's phase-detector error output to decide lock. It is the far end of the ADPLL's `ref_clk_i` / `error_o` interface: it generates the reference the loop tracks and reads back the error the loop reports. It sits beside the ADPLL in the top level, entirely in the `fpga_clk_i` domain.

## Interface

**Parameters**
- `DIV_WIDTH`, 16: width of the half-period counter.
- `ERROR_WIDTH`, 8: width of the signed phase error.
- `LOCK_TOL`, 2: maximum |error| counted as in tolerance.
- `LOCK_COUNT`, 16: consecutive in-tolerance samples needed to declare lock.
- `UNLOCK_COUNT`, 4: consecutive out-of-tolerance samples needed to drop lock.

**Ports**
- `fpga_clk_i` in 1: the single clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `enable_i` in 1: run the generator and monitor.
- `half_period_i` in DIV_WIDTH: reference half period, in `fpga_clk_i` cycles.
- `error_i` in ERROR_WIDTH, signed: phase-detector error, synchronous to `fpga_clk_i`.
- `ref_clk_o` out 1: generated reference clock.
- `ref_edge_o` out 1: one-cycle pulse in the cycle `ref_clk_o` goes high.
- `locked_o` out 1: lock flag.
- `lock_state_o` out 2: current state, IDLE=0, ACQUIRE=1, LOCKED=2.
- `lock_loss_o` out 1: one-cycle pulse on a LOCKED->ACQUIRE transition.
- `error_peak_o` out ERROR_WIDTH, unsigned: peak |error| seen while LOCKED.

## Operation

**Generator**
- The counter runs only while `enable_i`=1.
- At count == hp-1, `ref_clk_o` toggles and the counter returns to 0; otherwise the counter increments.
- `hp` is latched from `half_period_i` on every rising toggle and on leaving IDLE. A value of 0 is treated as 1.
- Changes to `half_period_i` mid-period are ignored until the next rising toggle.

**Sampling**
- On every falling toggle of `ref_clk_o`, `error_i` is registered and a one-cycle sample strobe is raised.
- abs = |error|, computed unsigned in ERROR_WIDTH bits. -2^(ERROR_WIDTH-1) maps to 2^(ERROR_WIDTH-1) with no saturation.
- A sample is good when abs <= LOCK_TOL.

**State machine**
- IDLE:
  - `enable_i`=1 -> ACQUIRE.
  - All counters are cleared and `ref_clk_o`=0.
- ACQUIRE:
  - A good sample increments the good count; a bad sample clears it.
  - When the good count reaches LOCK_COUNT -> LOCKED, and both counts clear.
- LOCKED:
  - A bad sample increments the bad count; a good sample clears it.
  - When the bad count reaches UNLOCK_COUNT -> ACQUIRE, `lock_loss_o` pulses, and both counts clear.
- From any state, `enable_i`=0 -> IDLE on the next edge. This clears the counters and `ref_clk_o` and does not pulse `lock_loss_o`.
- `locked_o` = (state == LOCKED).
- If `enable_i` falls in the same cycle as a sample strobe, the disable wins and the sample is discarded.

## Timing

- **Reset values:** every output 0, state IDLE, counters 0. Reset is honoured at any time, including mid-period.
- **First rising edge:** after `enable_i` rises, the state is ACQUIRE on the next edge. `ref_clk_o` first goes high hp cycles later, so it is high for hp cycles and low for hp cycles (period 2·hp).
- **`ref_edge_o`:** registered, and coincident with `ref_clk_o` rising.
- **Sample-to-state latency:** `error_i` is captured at the falling-toggle edge F. The state, counts, `locked_o`, `lock_loss_o` and `error_peak_o` update at edge F+1.
- **Upstream hold requirement:** `error_i` must be stable in the cycle before the falling toggle. The ADPLL's phase detector updates its output near the rising reference edge, which satisfies this.

## Configuration

- Macro: `ADPLL_REF_PEAK_EN`.
- Defined: `error_peak_o` is cleared on entry to LOCKED. At each LOCKED sample it becomes max(peak, abs), and it holds its value in ACQUIRE.
- Undefined: `error_peak_o` is tied to 0 and the tracker logic is absent.

## Structure

- Package `adpll_pkg` holds:
  - the `lock_state_t` enum (IDLE, ACQUIRE, LOCKED) and its 2-bit encoding;
  - default widths `ADPLL_ERROR_WIDTH`=8 and `ADPLL_DIV_WIDTH`=16.
- Sub-module `ref_divider` holds the half-period counter, hp latch, `ref_clk_o`, `ref_edge_o` and a falling-toggle strobe. Lock logic stays in the top module.

## Test plan

- **Period and first edge:** hp=4, enable -> `ref_clk_o` first rises 4 cycles after ACQUIRE; period 8 thereafter; `ref_edge_o` is one cycle per period.
- **Half-period change and hp=0:** change `half_period_i` 4->6 mid-high phase -> the current period stays 8 and the next period is 12. Set `half_period_i`=0 -> period 2.
- **Acquire and lock:** `error_i`=+2 for 15 samples, then -1 -> `locked_o` rises at F+1 of the 16th sample. A +3 at sample 10 instead resets the good count, so lock occurs 16 good samples after it.
- **Lock loss:** in LOCKED, feed 3 bad samples, 1 good, then 4 bad (-128) -> exactly one `lock_loss_o` pulse, after the 8th sample, and state returns to ACQUIRE.
- **Peak tracker (macro on):** LOCKED samples 1, -2, 0 -> `error_peak_o`=2. With the macro off -> 0.
- **Disable and reset:** drop `enable_i` while LOCKED -> IDLE next edge, `ref_clk_o`=0, no `lock_loss_o` pulse. Assert `reset_i` mid-period -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared types and default widths for the ADPLL reference/lock monitor.
package adpll_pkg;

  localparam int ADPLL_ERROR_WIDTH = 8;
  localparam int ADPLL_DIV_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

endpackage

// File: rtl/ref_divider.sv
// Reference clock generator: half-period counter, hp latch, ref clock, rising-edge pulse
// and a combinational falling-toggle strobe (high in the cycle that ends with the fall).
module ref_divider
  import adpll_pkg::*;
#(
  parameter int DIV_WIDTH = ADPLL_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] half_period_i,
  output logic                 ref_clk_o,
  output logic                 ref_edge_o,
  output logic                 fall_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] hp_q, hp_d;
  logic [DIV_WIDTH-1:0] hp_eff;
  logic                 ref_clk_q, ref_clk_d;
  logic                 edge_q, edge_d;
  logic                 toggle;

  always_comb begin
    hp_eff    = (half_period_i == '0) ? DIV_WIDTH'(1) : half_period_i;
    toggle    = run_i && (cnt_q == hp_q - DIV_WIDTH'(1));
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    ref_clk_d = ref_clk_q;
    edge_d    = 1'b0;
    // While stopped the period is re-latched every cycle, so the value present
    // when the generator starts is the one used for the first half period.
    if (!run_i) begin
      cnt_d     = '0;
      ref_clk_d = 1'b0;
      hp_d      = hp_eff;
    end else if (toggle) begin
      cnt_d     = '0;
      ref_clk_d = ~ref_clk_q;
      edge_d    = ~ref_clk_q;
      if (!ref_clk_q) hp_d = hp_eff;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      hp_q      <= DIV_WIDTH'(1);
      ref_clk_q <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      ref_clk_q <= ref_clk_d;
      edge_q    <= edge_d;
    end
  end

  assign ref_clk_o  = ref_clk_q;
  assign ref_edge_o = edge_q;
  assign fall_o     = toggle && ref_clk_q;

endmodule

// File: rtl/adpll_ref_lock_monitor.sv
// Generates the ADPLL reference clock and judges lock from the loop's phase error.
// Optional peak |error| tracker while LOCKED is built when ADPLL_REF_PEAK_EN is defined.
module adpll_ref_lock_monitor
  import adpll_pkg::*;
#(
  parameter int DIV_WIDTH    = ADPLL_DIV_WIDTH,
  parameter int ERROR_WIDTH  = ADPLL_ERROR_WIDTH,
  parameter int LOCK_TOL     = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                          fpga_clk_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic [DIV_WIDTH-1:0]          half_period_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  output logic                          ref_clk_o,
  output logic                          ref_edge_o,
  output logic                          locked_o,
  output logic [1:0]                    lock_state_o,
  output logic                          lock_loss_o,
  output logic [ERROR_WIDTH-1:0]        error_peak_o
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  lock_state_t            state_q, state_d;
  logic [CNT_W-1:0]       good_q, good_d, good_inc;
  logic [CNT_W-1:0]       bad_q, bad_d, bad_inc;
  logic                   loss_q, loss_d;
  logic [ERROR_WIDTH-1:0] sample_q, sample_d;
  logic                   strobe_q, strobe_d;
  logic [ERROR_WIDTH-1:0] abs_v;
  logic                   sample_good;
  logic                   fall;
  logic                   run;

  assign run = enable_i && (state_q != IDLE);

  ref_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk_i        (fpga_clk_i),
    .rst_i        (reset_i),
    .run_i        (run),
    .half_period_i(half_period_i),
    .ref_clk_o    (ref_clk_o),
    .ref_edge_o   (ref_edge_o),
    .fall_o       (fall)
  );

  // Error is captured on the falling-toggle edge; the FSM consumes it one edge later.
  always_comb begin
    sample_d = fall ? error_i : sample_q;
    strobe_d = fall;
  end

  // Magnitude in ERROR_WIDTH unsigned bits: the most negative code maps to 2^(W-1).
  always_comb begin
    abs_v       = sample_q[ERROR_WIDTH-1] ? (~sample_q + ERROR_WIDTH'(1)) : sample_q;
    sample_good = (abs_v <= ERROR_WIDTH'(LOCK_TOL));
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      good_q   <= '0;
      bad_q    <= '0;
      loss_q   <= 1'b0;
      sample_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      loss_q   <= loss_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
    end
  end

  // A disable overrides everything, including a strobe in the same cycle.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    loss_d   = 1'b0;
    good_inc = good_q + CNT_W'(1);
    bad_inc  = bad_q + CNT_W'(1);
    if (!enable_i) begin
      state_d = IDLE;
      good_d  = '0;
      bad_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          good_d  = '0;
          bad_d   = '0;
        end
        ACQUIRE: begin
          if (strobe_q) begin
            if (!sample_good) begin
              good_d = '0;
            end else if (good_inc == CNT_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_inc;
            end
          end
        end
        LOCKED: begin
          if (strobe_q) begin
            if (sample_good) begin
              bad_d = '0;
            end else if (bad_inc == CNT_W'(UNLOCK_COUNT)) begin
              state_d = ACQUIRE;
              loss_d  = 1'b1;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
          bad_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked_o     = (state_q == LOCKED);
    lock_state_o = state_q;
    lock_loss_o  = loss_q;
  end

`ifdef ADPLL_REF_PEAK_EN
  logic [ERROR_WIDTH-1:0] peak_q, peak_d;

  // Cleared on entering LOCKED, grows on every LOCKED sample, holds otherwise.
  always_comb begin
    peak_d = peak_q;
    if (enable_i && strobe_q) begin
      if (state_q == ACQUIRE && state_d == LOCKED) begin
        peak_d = '0;
      end else if (state_q == LOCKED && abs_v > peak_q) begin
        peak_d = abs_v;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign error_peak_o = peak_q;
`else
  assign error_peak_o = '0;
`endif

endmodule

// File: tb/tb_adpll_ref_lock_monitor.sv
// Self-checking bench for adpll_ref_lock_monitor: reference period/edge timing and
// per-sample lock-state scoreboard; peak expectations follow ADPLL_REF_PEAK_EN.
module tb_adpll_ref_lock_monitor;
  import adpll_pkg::*;

  localparam int DW = 16;
  localparam int EW = 8;
`ifdef ADPLL_REF_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                 fpga_clk_i = 1'b0;
  logic                 reset_i;
  logic                 enable_i;
  logic [DW-1:0]        half_period_i;
  logic signed [EW-1:0] error_i;
  logic                 ref_clk_o, ref_edge_o, locked_o, lock_loss_o;
  logic [1:0]           lock_state_o;
  logic [EW-1:0]        error_peak_o;

  always #5 fpga_clk_i = ~fpga_clk_i;

  int cyc = 0;
  always @(posedge fpga_clk_i) cyc <= cyc + 1;

  adpll_ref_lock_monitor dut (
    .fpga_clk_i   (fpga_clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .half_period_i(half_period_i),
    .error_i      (error_i),
    .ref_clk_o    (ref_clk_o),
    .ref_edge_o   (ref_edge_o),
    .locked_o     (locked_o),
    .lock_state_o (lock_state_o),
    .lock_loss_o  (lock_loss_o),
    .error_peak_o (error_peak_o)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_bad    = 0;
  logic [31:0] edge_q[$];
  logic [10:0] exp_q[$];
  int          stim_q[$];
  bit          mon_edges = 1'b0;
  bit          pending   = 1'b0;
  logic        prev_ref  = 1'b0;
  int          samp_idx, lock_idx, loss_idx, loss_cnt;
  logic [7:0]  peak_at_29;
  int          m_state, m_good, m_bad, m_peak;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge fpga_clk_i);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  // Sample-level reference: expected {state, loss, peak} after one error sample.
  task automatic push_sample(input int e);
    int   a;
    bit   good;
    bit   m_loss;
    a      = (e < 0) ? -e : e;
    good   = (a <= 2);
    m_loss = 1'b0;
    if (m_state == 1) begin
      if (good) begin
        m_good++;
        if (m_good == 16) begin
          m_state = 2; m_good = 0; m_bad = 0; m_peak = 0;
        end
      end else begin
        m_good = 0;
      end
    end else if (m_state == 2) begin
      if (PEAK_ON && a > m_peak) m_peak = a;
      if (!good) begin
        m_bad++;
        if (m_bad == 4) begin
          m_state = 1; m_good = 0; m_bad = 0; m_loss = 1'b1;
        end
      end else begin
        m_bad = 0;
      end
    end
    exp_q.push_back({2'(m_state), m_loss, 8'(m_peak)});
  endtask

  task automatic begin_scenario();
    m_state = 1; m_good = 0; m_bad = 0;
    samp_idx = 0; lock_idx = 0; loss_idx = 0; loss_cnt = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0 || pending) && t < 3000) begin
      step();
      t++;
    end
    check_val("drain", 32'(stim_q.size() + exp_q.size()), 32'd0);
  endtask

  // ---------------- driver + monitor ----------------
  initial begin
    int          e;
    logic [10:0] ev;
    forever begin
      @(posedge fpga_clk_i);
      #2;
      if (mon_edges && ref_edge_o) begin
        if (edge_q.size() == 0) check_val("edge_extra", 32'(cyc), 32'hFFFF_FFFF);
        else check_val("edge_cycle", 32'(cyc), edge_q.pop_front());
      end
      if (pending) begin
        pending = 1'b0;
        samp_idx++;
        ev = exp_q.pop_front();
        check_val("sample", {21'd0, lock_state_o, lock_loss_o, error_peak_o}, {21'd0, ev});
        check_val("locked", 32'(locked_o), 32'(ev[10:9] == 2'd2));
        if (locked_o && lock_idx == 0) lock_idx = samp_idx;
        if (samp_idx == 29) peak_at_29 = error_peak_o;
      end
      if (lock_loss_o) begin
        loss_cnt++;
        loss_idx = samp_idx;
      end
      if (prev_ref && !ref_clk_o && exp_q.size() > 0) pending = 1'b1;
      if (ref_edge_o && stim_q.size() > 0) begin
        e       = stim_q.pop_front();
        error_i = EW'(e);
        push_sample(e);
      end
      prev_ref = ref_clk_o;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int a0;
    int t;
    reset_i       = 1'b1;
    enable_i      = 1'b0;
    half_period_i = 16'd4;
    error_i       = '0;
    m_state = 0; m_good = 0; m_bad = 0; m_peak = 0;
    samp_idx = 0; lock_idx = 0; loss_idx = 0; loss_cnt = 0; peak_at_29 = 8'hEE;
    repeat (3) step();
    check_val("rst_ref_clk", 32'(ref_clk_o), 32'd0);
    check_val("rst_ref_edge", 32'(ref_edge_o), 32'd0);
    check_val("rst_locked", 32'(locked_o), 32'd0);
    check_val("rst_state", 32'(lock_state_o), 32'd0);
    check_val("rst_loss", 32'(lock_loss_o), 32'd0);
    check_val("rst_peak", 32'(error_peak_o), 32'd0);
    reset_i = 1'b0;
    step();

    // Period, first edge, mid-period hp change and hp=0
    enable_i = 1'b1;
    a0 = cyc + 1;
    edge_q.push_back(32'(a0 + 4));
    edge_q.push_back(32'(a0 + 12));
    edge_q.push_back(32'(a0 + 20));
    edge_q.push_back(32'(a0 + 32));
    edge_q.push_back(32'(a0 + 44));
    edge_q.push_back(32'(a0 + 46));
    edge_q.push_back(32'(a0 + 48));
    mon_edges = 1'b1;
    wait_cyc(a0);
    check_val("acq_after_en", 32'(lock_state_o), 32'd1);
    wait_cyc(a0 + 3);
    check_val("ref_low_pre", 32'(ref_clk_o), 32'd0);
    wait_cyc(a0 + 4);
    check_val("ref_first_high", 32'(ref_clk_o), 32'd1);
    wait_cyc(a0 + 8);
    check_val("ref_first_low", 32'(ref_clk_o), 32'd0);
    wait_cyc(a0 + 14);
    check_val("ref_mid_high", 32'(ref_clk_o), 32'd1);
    half_period_i = 16'd6;
    wait_cyc(a0 + 34);
    half_period_i = 16'd0;
    wait_cyc(a0 + 49);
    mon_edges = 1'b0;
    enable_i  = 1'b0;
    step();
    check_val("dis_state", 32'(lock_state_o), 32'd0);
    check_val("dis_ref_clk", 32'(ref_clk_o), 32'd0);
    check_val("edges_left", 32'(edge_q.size()), 32'd0);
    half_period_i = 16'd4;
    step();

    // Acquire: 15 x +2 then -1, lock on the 16th sample
    begin_scenario();
    for (int i = 0; i < 15; i++) stim_q.push_back(2);
    stim_q.push_back(-1);
    enable_i = 1'b1;
    drain();
    check_val("lock_idx_a", 32'(lock_idx), 32'd16);
    enable_i = 1'b0;
    repeat (2) step();

    // Bad sample at 10 restarts the count; then peak samples, lock loss and relock
    begin_scenario();
    for (int i = 0; i < 9; i++) stim_q.push_back(0);
    stim_q.push_back(3);
    for (int i = 0; i < 16; i++) stim_q.push_back(1);
    stim_q.push_back(1);
    stim_q.push_back(-2);
    stim_q.push_back(0);
    for (int i = 0; i < 3; i++) stim_q.push_back(5);
    stim_q.push_back(0);
    for (int i = 0; i < 4; i++) stim_q.push_back(-128);
    for (int i = 0; i < 16; i++) stim_q.push_back(0);
    enable_i = 1'b1;
    drain();
    check_val("lock_idx_b", 32'(lock_idx), 32'd26);
    check_val("peak_after_3", 32'(peak_at_29), PEAK_ON ? 32'd2 : 32'd0);
    check_val("loss_count", 32'(loss_cnt), 32'd1);
    check_val("loss_idx", 32'(loss_idx), 32'd37);
    check_val("relocked", 32'(lock_state_o), 32'd2);

    // Disable while LOCKED with ref high
    t = 0;
    while (!ref_clk_o && t < 40) begin
      step();
      t++;
    end
    check_val("ref_high_pre_dis", 32'(ref_clk_o), 32'd1);
    enable_i = 1'b0;
    step();
    check_val("dis2_state", 32'(lock_state_o), 32'd0);
    check_val("dis2_ref_clk", 32'(ref_clk_o), 32'd0);
    check_val("dis2_locked", 32'(locked_o), 32'd0);
    check_val("dis2_loss", 32'(lock_loss_o), 32'd0);
    repeat (3) step();
    check_val("dis2_no_loss", 32'(loss_cnt), 32'd1);

    // Asynchronous reset mid-period
    enable_i = 1'b1;
    t = 0;
    while (!ref_clk_o && t < 40) begin
      step();
      t++;
    end
    check_val("ref_high_pre_rst", 32'(ref_clk_o), 32'd1);
    #3;
    reset_i = 1'b1;
    #1;
    check_val("arst_ref_clk", 32'(ref_clk_o), 32'd0);
    check_val("arst_ref_edge", 32'(ref_edge_o), 32'd0);
    check_val("arst_locked", 32'(locked_o), 32'd0);
    check_val("arst_state", 32'(lock_state_o), 32'd0);
    check_val("arst_loss", 32'(lock_loss_o), 32'd0);
    check_val("arst_peak", 32'(error_peak_o), 32'd0);
    enable_i = 1'b0;
    step();
    reset_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
